instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the single-cycle RISC-V core. Holds the program counter, requests instructions from instruction memory over a ready-based handshake, and latches each returned word into an instruction register. Presents the word and its opcode field to the main decoder and datapath, then computes the next PC (sequential or branch target) when the datapath signals completion. Also flags misaligned targets and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] are required to be 0 and are not checked.
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  byte address of the fetch; equals pc.
- imem_ready  input  1  memory has a word on imem_rdata this cycle; sampled only while imem_req=1.
- imem_rdata  input  32  instruction word returned by memory.
- instr  output  32  latched instruction register.
- opcode  output  7  instr[6:0], fed to the main decoder.
- instr_valid  output  1  instr/opcode are valid for execution.
- pc  output  32  address of the instruction currently fetched or executing.
- advance  input  1  datapath finished the current instruction; sampled only while instr_valid=1.
- branch_taken  input  1  with advance: take branch target.
- branch_offset  input  32  signed byte offset (sign-extended immediate), used when branch_taken=1.
- fetch_fault  output  1  sticky misaligned-target fault.
- retired  output  32  count of instructions retired since reset.

## Operation
- States: IDLE, FETCH, ISSUE, FAULT.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=32'h0000_0013 (NOP), retired=0.
  - imem_req=0, instr_valid=0, fetch_fault=0.
- IDLE: no outputs asserted; unconditionally moves to FETCH on the next edge.
- FETCH:
  - imem_req=1, imem_addr=pc; instr_valid=0.
  - On an edge with imem_ready=1: instr<=imem_rdata; state goes to ISSUE.
  - Otherwise the stage stays in FETCH with pc unchanged (unbounded wait).
- ISSUE:
  - instr_valid=1, imem_req=0; instr and pc are held stable.
  - On an edge with advance=1, the target is computed:
    - branch_taken=0: target = pc+4.
    - branch_taken=1: target = pc+branch_offset.
    - Both sums wrap modulo 2^32.
  - Within the same edge, retired increments (wraps 32'hFFFF_FFFF to 0), because the current instruction is complete.
  - If target[1:0]==0: pc<=target and state goes to FETCH.
  - Otherwise: pc is unchanged, fetch_fault<=1, and state goes to FAULT.
- FAULT: imem_req=0, instr_valid=0, fetch_fault=1. The stage holds here until reset; all inputs are ignored.
- Ignored inputs:
  - advance, branch_taken and branch_offset in any state other than ISSUE.
  - imem_ready outside FETCH.
- opcode is always instr[6:0], including in reset (7'h13).

## Timing
- All state updates on the rising edge of clk; reset acts immediately and asynchronously.
- imem_req, instr_valid and fetch_fault are decoded from the registered state only; there is no combinational path from inputs to outputs.
- Minimum cycle per instruction: 1 FETCH cycle (imem_ready=1 immediately) plus 1 ISSUE cycle (advance=1 immediately), i.e. 2 clocks.
- After reset release: 1 IDLE cycle, then imem_req=1 in the next cycle.
- The instruction is visible on instr the cycle after the edge that sampled imem_ready=1.
- The new pc is visible, with imem_req=1, the cycle after the edge that sampled advance=1.
- Reset mid-FETCH or mid-ISSUE: the in-flight instruction is discarded, the count is not incremented, and the stage restarts from RESET_PC through IDLE.
- Any late imem_ready is ignored after reset until the stage is back in FETCH.

## Test plan
- Reset, then memory ready every cycle returning 32'h0000_0033, with advance=1 held:
  - imem_addr sequence 0,4,8,12, one address per 2 clocks.
  - retired=3 after the third ISSUE edge.
  - instr_valid alternates 0/1.
- Memory waits 3 cycles with imem_ready=0:
  - imem_req stays 1 and imem_addr stays constant.
  - instr changes only at the edge where imem_ready=1.
  - instr_valid rises one cycle later.
- At pc=32'h10: branch_taken=1, branch_offset=32'hFFFF_FFF8 -> next imem_addr=32'h08.
  - Then branch_offset=32'h20 from 32'h08 -> next imem_addr=32'h28.
- At pc=32'h10: branch_taken=1, branch_offset=32'h6 -> fetch_fault=1 and pc stays 32'h10.
  - imem_req remains 0 forever, and retired increments by 1.
  - Asserting rst_n=0 clears the fault; pc returns to RESET_PC.
- RESET_PC=32'hFFFF_FFFC, advance with branch_taken=0 -> next imem_addr=32'h0000_0000 (wrap), with no fault.
- Assert rst_n=0 for a partial cycle while in ISSUE with advance=1:
  - Outputs return to reset values immediately.
  - retired=0 and the first imem_addr is RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the PC, fetches words over a ready handshake,
// latches them into the instruction register and steps the PC on completion.
//
// state | meaning
// IDLE  | one quiet cycle after reset before the first request
// FETCH | imem_req high, waiting for imem_ready to capture the word
// ISSUE | instr valid for the datapath, waiting for advance
// FAULT | misaligned target seen, parked until reset
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        advance,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    output logic        fetch_fault,
    output logic [31:0] retired
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] retired_q;
    logic [31:0] target;
    logic        target_ok;

    // Candidate next PC; both sums wrap naturally at 32 bits.
    always_comb begin
        target    = branch_taken ? (pc_q + branch_offset) : (pc_q + 32'd4);
        target_ok = (target[1:0] == 2'b00);
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (imem_ready) state_next = ISSUE;
            ISSUE:   if (advance) state_next = target_ok ? FETCH : FAULT;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // PC, instruction register and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= NOP;
            retired_q <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) instr_q <= imem_rdata;
                end
                ISSUE: begin
                    if (advance) begin
                        // The instruction completes even when its successor faults.
                        retired_q <= retired_q + 32'd1;
                        if (target_ok) pc_q <= target;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake and status outputs come from the registered state only.
    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == ISSUE);
        fetch_fault = (state == FAULT);
        imem_addr   = pc_q;
        pc          = pc_q;
        instr       = instr_q;
        opcode      = instr_q[6:0];
        retired     = retired_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic, every
// cycle compared against a behavioural model of the fetch stage.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        instr_valid;
    logic [31:0] pc;
    logic        advance;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        fetch_fault;
    logic [31:0] retired;

    // second instance for the wrap-around reset address
    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic [31:0] instr2;
    logic [6:0]  opcode2;
    logic        valid2;
    logic [31:0] pc2;
    logic        fault2;
    logic [31:0] retired2;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc),
        .advance(advance), .branch_taken(branch_taken), .branch_offset(branch_offset),
        .fetch_fault(fetch_fault), .retired(retired)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(1'b1), .imem_rdata(32'h0000_0013),
        .instr(instr2), .opcode(opcode2), .instr_valid(valid2), .pc(pc2),
        .advance(1'b1), .branch_taken(1'b0), .branch_offset(32'h0),
        .fetch_fault(fault2), .retired(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: which phase the stage is in and its architectural values.
    localparam int M_IDLE = 0, M_FETCH = 1, M_ISSUE = 2, M_FAULT = 3;
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = M_IDLE;
        m_pc    = 32'h0;
        m_instr = 32'h0000_0013;
        m_ret   = 32'h0;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    function automatic void model_edge();
        longint unsigned nxt;
        case (m_phase)
            M_IDLE:  m_phase = M_FETCH;
            M_FETCH: if (imem_ready) begin
                m_instr = imem_rdata;
                m_phase = M_ISSUE;
            end
            M_ISSUE: if (advance) begin
                nxt   = (longint'(m_pc) + (branch_taken ? longint'(branch_offset) : 64'd4)) % 64'h1_0000_0000;
                m_ret = m_ret + 1;
                if (nxt % 4 == 0) begin
                    m_pc    = nxt[31:0];
                    m_phase = M_FETCH;
                end else begin
                    m_phase = M_FAULT;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] mi;
        mi = m_instr;
        chk({tag, ".req"},    {31'b0, imem_req},    {31'b0, m_phase == M_FETCH});
        chk({tag, ".valid"},  {31'b0, instr_valid}, {31'b0, m_phase == M_ISSUE});
        chk({tag, ".fault"},  {31'b0, fetch_fault}, {31'b0, m_phase == M_FAULT});
        chk({tag, ".addr"},   imem_addr, m_pc);
        chk({tag, ".pc"},     pc, m_pc);
        chk({tag, ".instr"},  instr, m_instr);
        chk({tag, ".opcode"}, {25'b0, opcode}, {25'b0, mi[6:0]});
        chk({tag, ".retired"}, retired, m_ret);
    endtask

    task automatic step(input string tag, input logic r, input logic [31:0] d,
                        input logic a, input logic b, input logic [31:0] o);
        imem_ready    = r;
        imem_rdata    = d;
        advance       = a;
        branch_taken  = b;
        branch_offset = o;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    // Called at a falling edge; pulses reset between edges and checks the
    // outputs collapse immediately, returning before the next rising edge.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, ".rst_req"},   {31'b0, imem_req},    32'd0);
        chk({tag, ".rst_valid"}, {31'b0, instr_valid}, 32'd0);
        chk({tag, ".rst_fault"}, {31'b0, fetch_fault}, 32'd0);
        chk({tag, ".rst_pc"},    pc, 32'h0);
        chk({tag, ".rst_instr"}, instr, 32'h0000_0013);
        chk({tag, ".rst_ret"},   retired, 32'h0);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // Run sequential fetches until the model is in ISSUE at the wanted pc.
    task automatic run_to_issue(input logic [31:0] want);
        int budget;
        budget = 0;
        while (!(m_phase == M_ISSUE && m_pc == want) && budget < 200) begin
            step("seek", 1'b1, $urandom, (m_phase == M_ISSUE), 1'b0, 32'h0);
            budget++;
        end
        chk("seek_timeout", {31'b0, budget < 200}, 32'd1);
    endtask

    initial begin
        logic [31:0] off;
        rst_n = 1'b0;
        rst2_n = 1'b0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        advance = 1'b0;
        branch_taken = 1'b0;
        branch_offset = 32'h0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;

        // back-to-back fetch/issue, memory always ready, advance held
        for (int i = 0; i < 7; i++) step("seq", 1'b1, 32'h0000_0033, 1'b1, 1'b0, 32'h0);
        chk("seq_addr12", imem_addr, 32'd12);
        chk("seq_ret3", retired, 32'd3);
        chk("seq_req", {31'b0, imem_req}, 32'd1);

        // memory stalls three cycles
        for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        chk("stall_addr", imem_addr, 32'd12);
        step("stall_go", 1'b1, 32'h0040_0093, 1'b0, 1'b0, 32'h0);
        chk("stall_instr", instr, 32'h0040_0093);
        step("hold", 1'b1, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
        step("hold2", 1'b0, 32'h2222_2222, 1'b1, 1'b0, 32'h0);

        // backward then forward branch
        run_to_issue(32'h10);
        step("br_back", 1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        chk("br_back_addr", imem_addr, 32'h08);
        step("br_fetch", 1'b1, 32'h0000_0063, 1'b0, 1'b0, 32'h0);
        step("br_fwd", 1'b0, 32'h0, 1'b1, 1'b1, 32'h20);
        chk("br_fwd_addr", imem_addr, 32'h28);

        // misaligned target parks the stage
        do_reset("f");
        step("f0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run_to_issue(32'h10);
        step("fault", 1'b1, 32'h0, 1'b1, 1'b1, 32'h6);
        chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
        chk("fault_pc", pc, 32'h10);
        chk("fault_ret", retired, 32'd5);
        for (int i = 0; i < 6; i++) step("fault_hold", 1'b1, $urandom, 1'b1, $urandom_range(0, 1), $urandom);
        do_reset("fclr");
        step("fclr_idle", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);

        // randomized traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            off = 32'($urandom_range(0, 64)) * 4;
            if ($urandom_range(0, 1) == 1) off = -off;
            if ($urandom_range(0, 11) == 0) off = off + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 79) == 0 || (m_phase == M_FAULT && $urandom_range(0, 7) == 0))
                do_reset("rnd");
            step("rnd", $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) == 0, off);
        end

        // partial-cycle reset in ISSUE with advance high
        do_reset("p");
        step("p0", 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run_to_issue(32'h8);
        advance = 1'b1;
        do_reset("pr");
        step("pr_idle", 1'b1, 32'h0, 1'b1, 1'b0, 32'h0);
        chk("pr_addr", imem_addr, 32'h0);
        chk("pr_ret", retired, 32'h0);

        // reset address at the top of the space wraps to zero
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        chk("w_idle_req", {31'b0, req2}, 32'd0);
        @(negedge clk);
        chk("w_req", {31'b0, req2}, 32'd1);
        chk("w_addr0", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_valid", {31'b0, valid2}, 32'd1);
        @(negedge clk);
        chk("w_addr1", addr2, 32'h0);
        chk("w_req1", {31'b0, req2}, 32'd1);
        chk("w_fault", {31'b0, fault2}, 32'd0);
        chk("w_ret", retired2, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
